fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Drives the instruction-memory request, decides when the PC register loads
// (sequential +4 or a branch target), and parks the pipeline on a load-use
// hazard or a fetch timeout.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      run enable; low returns to IDLE
//   hazard_i     downstream stall request (load-use)
//   br_taken_i   redirect request, target on br_target_i
//   br_target_i  redirect address
//   pc_i         current PC register value
//   imem_ack_i   memory accepts and returns the word at imem_addr_o
//   imem_req_o   fetch request
//   imem_addr_o  fetch address (always pc_i)
//   pc_next_o    value loaded into the PC register when pc_hold_o=0
//   pc_hold_o    1 = PC register keeps its value
//   flush_o      kills the instruction in IF/ID
//   err_o        sticky fetch-timeout flag
//
// Outputs are combinational decodes of registered state plus current inputs.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hazard_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] pc_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_next_o,
  output logic        pc_hold_o,
  output logic        flush_o,
  output logic        err_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 8;
  // Last counter value still allowed in WAIT; the next miss enters ERR.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   pend_tgt_q, pend_tgt_d;
  logic [AW-1:0]   pc_inc;

  // Sequential PC; natural 32-bit wrap from FFFF_FFFC to 0.
  assign pc_inc      = pc_i + AW'(4);
  assign imem_addr_o = pc_i;
  assign err_o       = (state_q == S_ERR);

  // State, wait counter and pending-redirect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    imem_req_o = 1'b0;
    pc_next_o  = RESET_PC;
    pc_hold_o  = 1'b1;
    flush_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pc_hold_o = 1'b0;
        cnt_d     = '0;
        pend_d    = 1'b0;
        if (start_i) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH, S_WAIT: begin
        imem_req_o = 1'b1;
        if (br_taken_i) begin
          // Redirect wins over ack and hazard; the in-flight fetch is dropped.
          pc_next_o = br_target_i;
          pc_hold_o = 1'b0;
          flush_o   = 1'b1;
          cnt_d     = '0;
          state_d   = S_FETCH;
        end else if (imem_ack_i) begin
          pc_next_o = pc_inc;
          pc_hold_o = 1'b0;
          cnt_d     = '0;
          state_d   = hazard_i ? S_HOLD : S_FETCH;
        end else if (state_q == S_FETCH) begin
          cnt_d   = CW'(1);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q >= CNT_LAST) begin
            state_d = S_ERR;
          end
        end
        if (!start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_HOLD: begin
        if (br_taken_i) begin
          pend_d     = 1'b1;
          pend_tgt_d = br_target_i;
        end
        if (!start_i) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end else if (!hazard_i) begin
          state_d = S_FETCH;
          pend_d  = 1'b0;
          // A redirect arriving on the exit cycle itself is the latest write.
          if (br_taken_i || pend_q) begin
            pc_next_o = br_taken_i ? br_target_i : pend_tgt_q;
            pc_hold_o = 1'b0;
            flush_o   = 1'b1;
          end
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset cycle presents the idle outputs regardless of state.
    if (rst_i) begin
      imem_req_o = 1'b0;
      pc_hold_o  = 1'b0;
      pc_next_o  = RESET_PC;
      flush_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int unsigned TO  = 15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        hazard_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_next_o;
  logic        pc_hold_o;
  logic        flush_o;
  logic        err_o;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        hold;
    logic [31:0] pcn;
    logic        flush;
    logic        err;
  } obs_t;

  typedef struct packed {
    obs_t val;
    obs_t msk;
  } exp_t;

  exp_t sb[$];
  obs_t got[$];
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .hazard_i    (hazard_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .pc_i        (pc_i),
    .imem_ack_i  (imem_ack_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .pc_next_o   (pc_next_o),
    .pc_hold_o   (pc_hold_o),
    .flush_o     (flush_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle; pc_next is don't-care while holding.
  function automatic exp_t ex(input logic req, input logic [31:0] addr,
                              input logic hold, input logic [31:0] pcn,
                              input logic flush, input logic err);
    exp_t e;
    e.val.req   = req;
    e.val.addr  = addr;
    e.val.hold  = hold;
    e.val.pcn   = pcn;
    e.val.flush = flush;
    e.val.err   = err;
    e.msk       = '1;
    if (hold) e.msk.pcn = '0;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic start, input logic haz,
                       input logic br, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic ack);
    rst_i       = rst;
    start_i     = start;
    hazard_i    = haz;
    br_taken_i  = br;
    br_target_i = tgt;
    pc_i        = pc;
    imem_ack_i  = ack;
  endtask

  // Queue the expectation, capture the DUT mid-cycle, advance past the edge.
  task automatic tick(input exp_t e);
    obs_t o;
    sb.push_back(e);
    @(negedge clk);
    o.req   = imem_req_o;
    o.addr  = imem_addr_o;
    o.hold  = pc_hold_o;
    o.pcn   = pc_next_o;
    o.flush = flush_o;
    o.err   = err_o;
    got.push_back(o);
    @(posedge clk);
    #1;
  endtask

  // Reset cycle followed by an IDLE cycle with start=1; leaves DUT in FETCH.
  task automatic preamble(input logic [31:0] pc);
    drive(1, 0, 0, 0, 32'h0, pc, 0);
    tick(ex(0, pc, 0, RPC, 0, 0));
    drive(0, 1, 0, 0, 32'h0, pc, 0);
    tick(ex(0, pc, 0, RPC, 0, 0));
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h0000_1234);
    drive(0, 1, 0, 0, 32'h0, 32'h80, 0);
    tick(ex(1, 32'h80, 1, 32'h0, 0, 0));
    tick(ex(1, 32'h80, 1, 32'h0, 0, 0));
    drive(1, 1, 1, 1, 32'h999, 32'h80, 1);
    tick(ex(0, 32'h80, 0, RPC, 0, 0));
    drive(0, 0, 0, 0, 32'h0, 32'h80, 0);
    tick(ex(0, 32'h80, 0, RPC, 0, 0));
    tick(ex(0, 32'h80, 0, RPC, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL reset[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_stream();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 32'h0, 32'(i * 4), 1);
      tick(ex(1, 32'(i * 4), 0, 32'(i * 4 + 4), 0, 0));
    end
    drive(0, 0, 0, 0, 32'h0, 32'hC, 0);
    tick(ex(1, 32'hC, 1, 32'h0, 0, 0));
    tick(ex(0, 32'hC, 0, RPC, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL stream[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_latency();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h20);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 32'h0, 32'h20, 0);
      tick(ex(1, 32'h20, 1, 32'h0, 0, 0));
    end
    drive(0, 1, 0, 0, 32'h0, 32'h20, 1);
    tick(ex(1, 32'h20, 0, 32'h24, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h24, 0);
    tick(ex(1, 32'h24, 1, 32'h0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL latency[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h50);
    drive(0, 1, 0, 0, 32'h0, 32'h50, 0);
    tick(ex(1, 32'h50, 1, 32'h0, 0, 0));
    tick(ex(1, 32'h50, 1, 32'h0, 0, 0));
    drive(0, 1, 0, 1, 32'h100, 32'h50, 0);
    tick(ex(1, 32'h50, 0, 32'h100, 1, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h100, 0);
    tick(ex(1, 32'h100, 1, 32'h0, 0, 0));
    // Redirect beats simultaneous ack and hazard: must land in FETCH.
    drive(0, 1, 1, 1, 32'h200, 32'h100, 1);
    tick(ex(1, 32'h100, 0, 32'h200, 1, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h200, 0);
    tick(ex(1, 32'h200, 1, 32'h0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL redirect[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_hazard_pending();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h60);
    drive(0, 1, 1, 0, 32'h0, 32'h60, 1);
    tick(ex(1, 32'h60, 0, 32'h64, 0, 0));
    drive(0, 1, 1, 1, 32'h40, 32'h64, 0);
    tick(ex(0, 32'h64, 1, 32'h0, 0, 0));
    drive(0, 1, 1, 0, 32'h0, 32'h64, 0);
    tick(ex(0, 32'h64, 1, 32'h0, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h64, 0);
    tick(ex(0, 32'h64, 0, 32'h40, 1, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h40, 0);
    tick(ex(1, 32'h40, 1, 32'h0, 0, 0));
    // Two redirects while held: the later target is applied.
    drive(0, 1, 1, 0, 32'h0, 32'h40, 1);
    tick(ex(1, 32'h40, 0, 32'h44, 0, 0));
    drive(0, 1, 1, 1, 32'h300, 32'h44, 0);
    tick(ex(0, 32'h44, 1, 32'h0, 0, 0));
    drive(0, 1, 1, 1, 32'h400, 32'h44, 0);
    tick(ex(0, 32'h44, 1, 32'h0, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h44, 0);
    tick(ex(0, 32'h44, 0, 32'h400, 1, 0));
    // Hold with no redirect: plain exit, pending must have been cleared.
    drive(0, 1, 1, 0, 32'h0, 32'h400, 1);
    tick(ex(1, 32'h400, 0, 32'h404, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h404, 0);
    tick(ex(0, 32'h404, 1, 32'h0, 0, 0));
    tick(ex(1, 32'h404, 1, 32'h0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL hazard_pending[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_start_drop();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h70);
    drive(0, 1, 1, 0, 32'h0, 32'h70, 1);
    tick(ex(1, 32'h70, 0, 32'h74, 0, 0));
    drive(0, 1, 1, 1, 32'h500, 32'h74, 0);
    tick(ex(0, 32'h74, 1, 32'h0, 0, 0));
    drive(0, 0, 1, 0, 32'h0, 32'h74, 0);
    tick(ex(0, 32'h74, 1, 32'h0, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h74, 0);
    tick(ex(0, 32'h74, 0, RPC, 0, 0));
    drive(0, 1, 1, 0, 32'h0, 32'h74, 1);
    tick(ex(1, 32'h74, 0, 32'h78, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h78, 0);
    tick(ex(0, 32'h78, 1, 32'h0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL start_drop[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'h90);
    for (int i = 0; i < int'(TO); i++) begin
      drive(0, 1, 0, 0, 32'h0, 32'h90, 0);
      tick(ex(1, 32'h90, 1, 32'h0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, (i % 2) == 1, 0, 1, 32'h700, 32'h90, 1);
      tick(ex(0, 32'h90, 1, 32'h0, 0, 1));
    end
    drive(1, 0, 0, 0, 32'h0, 32'h90, 0);
    e = ex(0, 32'h90, 0, RPC, 0, 0);
    e.msk.err = 1'b0;
    tick(e);
    drive(0, 0, 0, 0, 32'h0, 32'h90, 0);
    tick(ex(0, 32'h90, 0, RPC, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL timeout[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    obs_t o;
    int   k = 0;
    preamble(32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 1);
    tick(ex(1, 32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 0));
    drive(0, 1, 0, 0, 32'h0, 32'h0, 0);
    tick(ex(1, 32'h0, 1, 32'h0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      n_checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_errors++;
        $display("FAIL wrap[%0d] got %h want %h mask %h", k, o, e.val, e.msk);
      end
      k++;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    test_reset();
    test_stream();
    test_latency();
    test_redirect();
    test_hazard_pending();
    test_start_drop();
    test_timeout();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
